// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
//   Sequencing FSM for a 2-way set-associative, write-back, write-allocate L1
//   cache. Decodes datapath status (hit, victim dirty, victim tag) into array
//   read/load strobes, way-steering selects and physical-memory handshakes.
//
//   Optional feature macro: CACHE_CTRL_PERF_EN
//     defined   -> saturating 32-bit hit/miss/writeback counters are built
//     undefined -> hit_count/miss_count/wb_count are tied to zero
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     mem_read/mem_write    CPU-side request, held until mem_resp
//     mem_address           request address
//     mem_resp              one-cycle completion pulse
//     hit_control           any-way hit from datapath
//     dirty_bit             LRU (victim) way dirty
//     tag_array_out         tag of LRU (victim) way
//     *_read                array read enables (high whenever out of reset)
//     data_write            CPU write into the hit way
//     force_data_write      line fill from pmem
//     force_data_read       steer victim way onto the pmem write path
//     tag/valid/lru/dirty_load  array load strobes
//     dirty_in, dirty_load_sel  dirty value and way select (0 hit, 1 LRU)
//     pmem_read/pmem_write  pmem request, held until pmem_resp
//     pmem_resp             pmem completion pulse
//     pmem_address          line-aligned pmem address (0 when idle)
//     hit_count, miss_count, wb_count  performance counters
// -----------------------------------------------------------------------------
module cache_control #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_tag    = 32 - s_offset - s_index
) (
  input  logic             clk,
  input  logic             rst_n,
  // CPU-side request
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      mem_address,
  output logic             mem_resp,
  // datapath status
  input  logic             hit_control,
  input  logic             dirty_bit,
  input  logic [s_tag-1:0] tag_array_out,
  // array read enables
  output logic             data_read,
  output logic             tag_read,
  output logic             valid_read,
  output logic             dirty_read,
  output logic             lru_read,
  // data-array strobes
  output logic             data_write,
  output logic             force_data_write,
  output logic             force_data_read,
  // array load strobes
  output logic             tag_load,
  output logic             valid_load,
  output logic             lru_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic             dirty_load_sel,
  // physical memory
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [31:0]      pmem_address,
  // performance counters
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
  output logic [31:0]      wb_count
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned CntW  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic req_c;
  logic is_write_c;
  logic unused_addr_bits;

  // A simultaneous read+write request is serviced as a write.
  assign req_c      = mem_read | mem_write;
  assign is_write_c = mem_write;

  // Byte-offset bits never reach pmem; addresses are line aligned.
  assign unused_addr_bits = ^mem_address[s_offset-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_c) state_d = CHECK;
      end
      CHECK: begin
        // A withdrawn request abandons the lookup without a response.
        if (!req_c)           state_d = IDLE;
        else if (hit_control) state_d = IDLE;
        else if (dirty_bit)   state_d = WRITEBACK;
        else                  state_d = FETCH;
      end
      WRITEBACK: begin
        if (pmem_resp) state_d = FETCH;
      end
      FETCH: begin
        // After the fill the line is present, so the re-check hits.
        if (pmem_resp) state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    mem_resp         = 1'b0;
    data_read        = 1'b0;
    tag_read         = 1'b0;
    valid_read       = 1'b0;
    dirty_read       = 1'b0;
    lru_read         = 1'b0;
    data_write       = 1'b0;
    force_data_write = 1'b0;
    force_data_read  = 1'b0;
    tag_load         = 1'b0;
    valid_load       = 1'b0;
    lru_load         = 1'b0;
    dirty_load       = 1'b0;
    dirty_in         = 1'b0;
    dirty_load_sel   = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = AddrW'(0);

    if (rst_n) begin
      data_read  = 1'b1;
      tag_read   = 1'b1;
      valid_read = 1'b1;
      dirty_read = 1'b1;
      lru_read   = 1'b1;

      case (state_q)
        CHECK: begin
          if (req_c && hit_control) begin
            mem_resp = 1'b1;
            lru_load = 1'b1;
            // Write hit: update the hit way and mark it dirty.
            if (is_write_c) begin
              data_write     = 1'b1;
              dirty_load     = 1'b1;
              dirty_load_sel = 1'b0;
              dirty_in       = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write      = 1'b1;
          force_data_read = 1'b1;
          // Victim line address: its stored tag plus the current set index.
          pmem_address    = {tag_array_out,
                             mem_address[s_offset+s_index-1:s_offset],
                             {s_offset{1'b0}}};
        end
        FETCH: begin
          pmem_read    = 1'b1;
          pmem_address = {mem_address[AddrW-1:s_offset], {s_offset{1'b0}}};
          // Fill cycle: install the line into the LRU way as clean.
          if (pmem_resp) begin
            force_data_write = 1'b1;
            tag_load         = 1'b1;
            valid_load       = 1'b1;
            dirty_load       = 1'b1;
            dirty_load_sel   = 1'b1;
            dirty_in         = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [CntW-1:0] hit_cnt_q;
  logic [CntW-1:0] miss_cnt_q;
  logic [CntW-1:0] wb_cnt_q;
  logic            from_idle_q;
  logic            hit_evt_c;
  logic            miss_evt_c;
  logic            wb_evt_c;

  // Distinguishes a first lookup from the re-check that follows a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      from_idle_q <= 1'b0;
    end else if (state_q == IDLE) begin
      from_idle_q <= 1'b1;
    end else if (state_q == FETCH) begin
      from_idle_q <= 1'b0;
    end
  end

  assign hit_evt_c  = (state_q == CHECK) && req_c && hit_control && from_idle_q;
  assign miss_evt_c = (state_q == CHECK) && req_c && !hit_control;
  assign wb_evt_c   = miss_evt_c && dirty_bit;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= CntW'(0);
      miss_cnt_q <= CntW'(0);
      wb_cnt_q   <= CntW'(0);
    end else begin
      if (hit_evt_c && (hit_cnt_q != {CntW{1'b1}}))
        hit_cnt_q <= hit_cnt_q + CntW'(1);
      if (miss_evt_c && (miss_cnt_q != {CntW{1'b1}}))
        miss_cnt_q <= miss_cnt_q + CntW'(1);
      if (wb_evt_c && (wb_cnt_q != {CntW{1'b1}}))
        wb_cnt_q <= wb_cnt_q + CntW'(1);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  assign hit_count  = CntW'(0);
  assign miss_count = CntW'(0);
  assign wb_count   = CntW'(0);
`endif

endmodule
